gray_counter_conv: RTL and testbench
====================================

# gray_counter_conv

Parametrised Gray-code unit: a registered up/down Gray counter with load and wrap detection, plus an independent one-cycle-latency binary↔Gray conversion channel. It generalises the team's fixed 4-bit combinational Gray→binary prefix-XOR chain to any width and adds state, direction, load and a handshaked conversion path. It is used wherever a design needs single-bit-change sequences, such as pointers, encoders or position counters.

## Interface
- WIDTH, default 4, data/counter width; legal range WIDTH ≥ 2.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- en  in  1  advance counter one step this cycle
- up  in  1  direction: 1 = increment, 0 = decrement (binary sense)
- load  in  1  load counter from load_val (overrides en)
- load_gray  in  1  1 = load_val is Gray-coded, 0 = binary
- load_val  in  WIDTH  load value
- gray_q  out  WIDTH  counter value, Gray code
- bin_q  out  WIDTH  counter value, binary
- wrap  out  1  one-cycle pulse: last step wrapped past max/0
- cvt_valid_in  in  1  conversion request
- cvt_dir  in  1  0 = binary→Gray, 1 = Gray→binary
- cvt_in  in  WIDTH  value to convert
- cvt_out  out  WIDTH  converted value
- cvt_valid_out  out  1  cvt_out valid

## Operation
- Counter state is a binary register b; gray_q = b ^ (b >> 1). Both outputs are registered and updated in the same edge, so they are never skewed.
- Gray→binary: bin[WIDTH-1] = g[WIDTH-1]; bin[i] = bin[i+1] ^ g[i] (prefix XOR from MSB).
- Priority per edge: rst > load > en > hold.
- load: b ← load_val if load_gray=0, else b ← gray2bin(load_val). wrap ← 0.
- en (and no load): b ← b+1 if up, else b−1, modulo 2^WIDTH.
  - wrap ← 1 iff (up and b = 2^WIDTH−1) or (!up and b = 0).
  - Otherwise wrap ← 0.
- No en and no load: b holds; wrap ← 0.
- Conversion channel is independent of the counter; it may be used in the same cycle as a load or step.
  - On every edge: cvt_valid_out ← cvt_valid_in.
  - If cvt_valid_in: cvt_out ← (cvt_dir ? gray2bin(cvt_in) : bin2gray(cvt_in)).
  - Otherwise cvt_out holds its previous value.
- There is no backpressure: every request is accepted.

## Timing
- Reset values: gray_q = 0, bin_q = 0, wrap = 0, cvt_out = 0, cvt_valid_out = 0.
- Counter latency: 1 cycle. The new gray_q/bin_q are visible after the edge that samples en/load.
- wrap asserts in the same cycle as the wrapped value (e.g. bin_q = 0 after an up-wrap). It is high for exactly one cycle per wrapping step.
- Continuous en gives one step per cycle. Consecutive gray_q values differ in exactly one bit, including across wrap.
- Loads are exempt from the one-bit-change rule.
- Conversion latency: 1 cycle. Back-to-back requests produce back-to-back results.
- rst asserted mid-count or mid-conversion clears all state on that edge. Any in-flight cvt result is discarded (cvt_valid_out = 0 next cycle).
- Simultaneous load and en: load wins and no step is taken.
- Direction change takes effect on the same edge as the en it accompanies.

## Structure
- The package gray_pkg holds:
  - function bin2gray(logic [WIDTH-1:0])
  - function gray2bin(logic [WIDTH-1:0]), implementing the prefix-XOR chain
  - Both are parametrised by a width constant or a parameterised class wrapper.
- One combinational sub-module, gray_xor_prefix (parameter WIDTH, in g, out b), is instantiated twice: once for the load path and once for the conversion path.
- Everything else is a single always block plus output assigns.

## Test plan
- Reset, then WIDTH=4, en=1, up=1 for 17 cycles:
  - gray_q sequence is 0000, 0001, 0011, 0010, 0110, …, 1000, 0000.
  - Every transition changes one bit.
  - wrap pulses exactly once, in the cycle bin_q returns to 0.
- Load from 0000 with up=0, en=1:
  - bin_q = 1111, gray_q = 1000, wrap = 1 for one cycle.
  - Next cycle: bin_q = 1110, gray_q = 1001, wrap = 0.
- Load with load_gray=1, load_val=1011: bin_q = 1101, gray_q = 1011 next cycle.
- Load and en together with load_val=0101, load_gray=0: bin_q = 0101 (no step). Then en=1, up=1: bin_q = 0110.
- Conversion channel:
  - Requests (dir=1, 1111) then (dir=0, 1010) on consecutive cycles.
  - Expect cvt_out = 1010 then 1111, with cvt_valid_out high for two cycles.
  - Exhaustive sweep of all 16 codes both ways matches the package functions.
- rst asserted mid-count (bin_q = 0111) with cvt_valid_in=1: on the next cycle all outputs are 0 and cvt_valid_out = 0.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers. Functions work on a fixed maximum width; callers
// zero-extend narrower values and truncate the result back to their own width.
package gray_pkg;

  localparam int GRAY_MAX_W = 64;

  typedef logic [GRAY_MAX_W-1:0] gray_word_t;

  function automatic gray_word_t bin2gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  // Leading zero bits leave the running XOR unchanged, so zero-extended inputs
  // convert exactly as they would at their native width.
  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_xor_prefix.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all
// Gray bits from the MSB down to that position.
module gray_xor_prefix #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] b
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign b[i] = ^g[WIDTH-1:i];
  end

endmodule

// File: rtl/gray_counter_conv.sv
// Registered up/down Gray counter with load and wrap pulse, plus an independent
// one-cycle binary<->Gray conversion channel.
module gray_counter_conv
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic             load_gray,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] gray_q,
  output logic [WIDTH-1:0] bin_q,
  output logic             wrap,
  input  logic             cvt_valid_in,
  input  logic             cvt_dir,
  input  logic [WIDTH-1:0] cvt_in,
  output logic [WIDTH-1:0] cvt_out,
  output logic             cvt_valid_out
);

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_wrap;
  logic [WIDTH-1:0] r_cvt_out;
  logic             r_cvt_valid;

  logic [WIDTH-1:0] w_load_g2b;
  logic [WIDTH-1:0] w_cvt_g2b;
  logic [WIDTH-1:0] w_cvt_b2g;
  logic [WIDTH-1:0] w_cvt_res;
  logic [WIDTH-1:0] w_next_bin;
  logic [WIDTH-1:0] w_next_gray;
  logic             w_next_wrap;

  gray_xor_prefix #(.WIDTH(WIDTH)) u_load_g2b (
    .g (load_val),
    .b (w_load_g2b)
  );

  gray_xor_prefix #(.WIDTH(WIDTH)) u_cvt_g2b (
    .g (cvt_in),
    .b (w_cvt_g2b)
  );

  assign w_cvt_b2g = WIDTH'(bin2gray(gray_word_t'(cvt_in)));
  assign w_cvt_res = cvt_dir ? w_cvt_g2b : w_cvt_b2g;

  // NOTE: every output of a combinational block gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    w_next_bin  = r_bin;
    w_next_wrap = 1'b0;
    if (load) begin
      w_next_bin = load_gray ? w_load_g2b : load_val;
    end else if (en) begin
      if (up) begin
        w_next_bin  = r_bin + WIDTH'(1);
        w_next_wrap = &r_bin;
      end else begin
        w_next_bin  = r_bin - WIDTH'(1);
        w_next_wrap = ~|r_bin;
      end
    end
  end

  // Gray is registered from the same next-state value so gray_q and bin_q never skew.
  assign w_next_gray = WIDTH'(bin2gray(gray_word_t'(w_next_bin)));

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin       <= '0;
      r_gray      <= '0;
      r_wrap      <= 1'b0;
      r_cvt_out   <= '0;
      r_cvt_valid <= 1'b0;
    end else begin
      r_bin       <= w_next_bin;
      r_gray      <= w_next_gray;
      r_wrap      <= w_next_wrap;
      r_cvt_valid <= cvt_valid_in;
      if (cvt_valid_in) begin
        r_cvt_out <= w_cvt_res;
      end
    end
  end

  assign bin_q         = r_bin;
  assign gray_q        = r_gray;
  assign wrap          = r_wrap;
  assign cvt_out       = r_cvt_out;
  assign cvt_valid_out = r_cvt_valid;

endmodule

// File: tb/tb_gray_counter_conv.sv
// Scoreboard bench for gray_counter_conv (WIDTH=4): stimulus pushes expected
// results, a negedge monitor pops and compares them.
module tb_gray_counter_conv;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, en, up, load, load_gray;
  logic [W-1:0] load_val;
  logic [W-1:0] gray_q, bin_q;
  logic         wrap;
  logic         cvt_valid_in, cvt_dir;
  logic [W-1:0] cvt_in, cvt_out;
  logic         cvt_valid_out;

  gray_counter_conv #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .up            (up),
    .load          (load),
    .load_gray     (load_gray),
    .load_val      (load_val),
    .gray_q        (gray_q),
    .bin_q         (bin_q),
    .wrap          (wrap),
    .cvt_valid_in  (cvt_valid_in),
    .cvt_dir       (cvt_dir),
    .cvt_in        (cvt_in),
    .cvt_out       (cvt_out),
    .cvt_valid_out (cvt_valid_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Hand-computed 4-bit Gray codes, indexed by binary value.
  logic [W-1:0] gray_tbl [16] = '{
    4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
    4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000
  };

  typedef struct {
    int           due;
    logic [W-1:0] bin;
    logic [W-1:0] gray;
    logic         wrap;
    bit           one_bit;
    logic [W-1:0] cvt_hold;
  } cnt_exp_t;

  typedef struct {
    int           due;
    logic [W-1:0] val;
  } cvt_exp_t;

  cnt_exp_t cnt_q [$];
  cvt_exp_t cvt_q [$];

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] model_hold = '0;
  logic [W-1:0] prev_gray = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Records the expected state after the coming edge, then advances one cycle.
  task automatic issue(input logic [W-1:0] b, input logic w, input bit ob,
                       input logic [W-1:0] cexp);
    cnt_exp_t e;
    cvt_exp_t c;
    if (rst) begin
      model_hold = '0;
    end else if (cvt_valid_in) begin
      model_hold = cexp;
      c.due = cyc + 1;
      c.val = cexp;
      cvt_q.push_back(c);
    end
    e.due      = cyc + 1;
    e.bin      = b;
    e.gray     = gray_tbl[b];
    e.wrap     = w;
    e.one_bit  = ob;
    e.cvt_hold = model_hold;
    cnt_q.push_back(e);
    tick();
  endtask

  always @(negedge clk) begin
    if (cnt_q.size() > 0 && cnt_q[0].due == cyc) begin
      cnt_exp_t e;
      e = cnt_q.pop_front();
      check("bin_q", 32'(bin_q), 32'(e.bin));
      check("gray_q", 32'(gray_q), 32'(e.gray));
      check("wrap", 32'(wrap), 32'(e.wrap));
      if (e.one_bit) check("gray_one_bit_change", $countones(gray_q ^ prev_gray), 1);
      if (!cvt_valid_out) check("cvt_out_hold", 32'(cvt_out), 32'(e.cvt_hold));
      prev_gray = gray_q;
    end
    if (cvt_valid_out) begin
      if (cvt_q.size() == 0 || cvt_q[0].due != cyc) begin
        check("cvt_valid_spurious", 32'(cvt_valid_out), 0);
      end else begin
        cvt_exp_t c;
        c = cvt_q.pop_front();
        check("cvt_out", 32'(cvt_out), 32'(c.val));
      end
    end else if (cvt_q.size() > 0 && cvt_q[0].due == cyc) begin
      void'(cvt_q.pop_front());
      check("cvt_valid_missing", 32'(cvt_valid_out), 1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_gray = 1'b0;
    load_val = '0; cvt_valid_in = 1'b0; cvt_dir = 1'b0; cvt_in = '0;
    tick();
    issue(4'd0, 1'b0, 1'b0, '0);
    issue(4'd0, 1'b0, 1'b0, '0);

    // 17 up steps from reset: wraps to 0 on step 16, then 1
    rst = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      issue(W'(i % 16), (i == 16), 1'b1, '0);
    end

    // load 0000, then count down across zero
    en = 1'b0; load = 1'b1; load_val = 4'b0000;
    issue(4'b0000, 1'b0, 1'b0, '0);
    load = 1'b0; en = 1'b1; up = 1'b0;
    issue(4'b1111, 1'b1, 1'b1, '0);
    issue(4'b1110, 1'b0, 1'b1, '0);
    en = 1'b0;
    issue(4'b1110, 1'b0, 1'b0, '0);

    // Gray-coded load
    load = 1'b1; load_gray = 1'b1; load_val = 4'b1011;
    issue(4'b1101, 1'b0, 1'b0, '0);

    // load beats en; then a plain up step
    load_gray = 1'b0; load_val = 4'b0101; en = 1'b1; up = 1'b1;
    issue(4'b0101, 1'b0, 1'b0, '0);
    load = 1'b0;
    issue(4'b0110, 1'b0, 1'b1, '0);

    // load 1111 with en: no step and no wrap; next up step wraps
    load = 1'b1; load_val = 4'b1111;
    issue(4'b1111, 1'b0, 1'b0, '0);
    load = 1'b0;
    issue(4'b0000, 1'b1, 1'b1, '0);

    // back-to-back conversions, counter holding
    en = 1'b0; cvt_valid_in = 1'b1;
    cvt_dir = 1'b1; cvt_in = 4'b1111;
    issue(4'b0000, 1'b0, 1'b0, 4'b1010);
    cvt_dir = 1'b0; cvt_in = 4'b1010;
    issue(4'b0000, 1'b0, 1'b0, 4'b1111);

    // sweep all codes both directions
    for (int i = 0; i < 16; i++) begin
      cvt_dir = 1'b0; cvt_in = W'(i);
      issue(4'b0000, 1'b0, 1'b0, gray_tbl[i]);
      cvt_dir = 1'b1; cvt_in = gray_tbl[i];
      issue(4'b0000, 1'b0, 1'b0, W'(i));
    end
    cvt_valid_in = 1'b0; cvt_in = 4'b0011;
    issue(4'b0000, 1'b0, 1'b0, '0);

    // reset mid-count with a conversion in flight
    load = 1'b1; load_val = 4'b0110;
    issue(4'b0110, 1'b0, 1'b0, '0);
    load = 1'b0; en = 1'b1; up = 1'b1;
    issue(4'b0111, 1'b0, 1'b1, '0);
    rst = 1'b1; cvt_valid_in = 1'b1; cvt_dir = 1'b0; cvt_in = 4'b0101;
    issue(4'b0000, 1'b0, 1'b0, '0);
    rst = 1'b0; en = 1'b0; cvt_valid_in = 1'b0;
    issue(4'b0000, 1'b0, 1'b0, '0);

    tick();
    tick();
    check("counter_queue_drained", cnt_q.size(), 0);
    check("cvt_queue_drained", cvt_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
